// File: rtl/y86_stage_sequencer_if.sv
// Stage-sequencer bus: the start pulse, fetch/execute/memory status flowing in,
// and the per-stage strobes, processor status and counters flowing out.
// The master side is the sequencer; the slave side is the datapath/environment.
interface y86_stage_sequencer_if #(
    parameter int CNT_W = 32
) ();
    logic             start;
    logic [3:0]       icode;
    logic             invalid_instr;
    logic             imem_error;
    logic             dmem_error;
    logic             mem_ack;
    logic             cnd;
    logic             fetch_en;
    logic             decode_en;
    logic             exec_en;
    logic             cc_we;
    logic             mem_req;
    logic             wb_en;
    logic             pc_en;
    logic [2:0]       stat;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  start, icode, invalid_instr, imem_error, dmem_error, mem_ack, cnd,
        output fetch_en, decode_en, exec_en, cc_we, mem_req, wb_en, pc_en,
        output stat, busy, halted, instr_count, cycle_count
    );

    modport slave (
        output start, icode, invalid_instr, imem_error, dmem_error, mem_ack, cnd,
        input  fetch_en, decode_en, exec_en, cc_we, mem_req, wb_en, pc_en,
        input  stat, busy, halted, instr_count, cycle_count
    );
endinterface

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle control FSM for the Y86-64 sequential datapath. Walks each
// instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD,
// skipping stages the icode does not use, issuing a one-cycle strobe per
// stage, waiting on data memory with a timeout, and tracking processor status.
module y86_stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    y86_stage_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0]       STAT_AOK = 3'd1;
    localparam logic [2:0]       STAT_HLT = 3'd2;
    localparam logic [2:0]       STAT_ADR = 3'd3;
    localparam logic [2:0]       STAT_INS = 3'd4;
    localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
    function automatic logic uses_mem(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: uses_mem = 1'b1;
            default:                            uses_mem = 1'b0;
        endcase
    endfunction

    // Instructions that go straight from EXECUTE to a register write: cmov, irmovq, OPq.
    function automatic logic uses_wb_only(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h6: uses_wb_only = 1'b1;
            default:          uses_wb_only = 1'b0;
        endcase
    endfunction

    state_t           state_r;
    logic             fetch_en_r;
    logic             decode_en_r;
    logic             exec_en_r;
    logic             cc_we_r;
    logic             mem_req_r;
    logic             wb_phase_r;
    logic             pc_en_r;
    logic [2:0]       stat_r;
    logic             busy_r;
    logic             halted_r;
    logic [7:0]       tmo_r;
    logic [CNT_W-1:0] instr_count_r;
    logic [CNT_W-1:0] cycle_count_r;

    // Sequencer state, registered stage strobes, status and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            fetch_en_r    <= 1'b0;
            decode_en_r   <= 1'b0;
            exec_en_r     <= 1'b0;
            cc_we_r       <= 1'b0;
            mem_req_r     <= 1'b0;
            wb_phase_r    <= 1'b0;
            pc_en_r       <= 1'b0;
            stat_r        <= STAT_AOK;
            busy_r        <= 1'b0;
            halted_r      <= 1'b0;
            tmo_r         <= 8'd0;
            instr_count_r <= {CNT_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
        end else begin
            // Strobes are one-cycle pulses; each transition re-arms only its target's strobe.
            fetch_en_r  <= 1'b0;
            decode_en_r <= 1'b0;
            exec_en_r   <= 1'b0;
            cc_we_r     <= 1'b0;
            mem_req_r   <= 1'b0;
            wb_phase_r  <= 1'b0;
            pc_en_r     <= 1'b0;

            if (busy_r && (cycle_count_r != CNT_MAX)) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end else begin
                cycle_count_r <= cycle_count_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r    <= S_FETCH;
                        fetch_en_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_error) begin
                        state_r  <= S_HALT;
                        stat_r   <= STAT_ADR;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else if (bus.invalid_instr) begin
                        state_r  <= S_HALT;
                        stat_r   <= STAT_INS;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else if (bus.icode == 4'h0) begin
                        state_r  <= S_HALT;
                        stat_r   <= STAT_HLT;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else begin
                        state_r     <= S_DECODE;
                        decode_en_r <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state_r   <= S_EXECUTE;
                    exec_en_r <= 1'b1;
                    cc_we_r   <= (bus.icode == 4'h6);
                end
                S_EXECUTE: begin
                    if (uses_mem(bus.icode)) begin
                        state_r   <= S_MEMORY;
                        mem_req_r <= 1'b1;
                        tmo_r     <= 8'd0;
                    end else if (uses_wb_only(bus.icode)) begin
                        state_r    <= S_WRITEBACK;
                        wb_phase_r <= 1'b1;
                    end else begin
                        // nop and jXX (and anything unclassified) only update the PC.
                        state_r <= S_PCUPD;
                        pc_en_r <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    // An ack always wins over a timeout landing in the same cycle.
                    if (bus.mem_ack) begin
                        if (bus.dmem_error) begin
                            state_r  <= S_HALT;
                            stat_r   <= STAT_ADR;
                            busy_r   <= 1'b0;
                            halted_r <= 1'b1;
                        end else if (bus.icode == 4'h4) begin
                            state_r <= S_PCUPD;
                            pc_en_r <= 1'b1;
                        end else begin
                            state_r    <= S_WRITEBACK;
                            wb_phase_r <= 1'b1;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        state_r  <= S_HALT;
                        stat_r   <= STAT_ADR;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                    end else begin
                        state_r   <= S_MEMORY;
                        mem_req_r <= 1'b1;
                        tmo_r     <= tmo_r + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    state_r <= S_PCUPD;
                    pc_en_r <= 1'b1;
                end
                S_PCUPD: begin
                    state_r       <= S_FETCH;
                    fetch_en_r    <= 1'b1;
                    instr_count_r <= instr_count_r + CNT_ONE;
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_en    = fetch_en_r;
    assign bus.decode_en   = decode_en_r;
    assign bus.exec_en     = exec_en_r;
    assign bus.cc_we       = cc_we_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.pc_en       = pc_en_r;
    assign bus.stat        = stat_r;
    assign bus.busy        = busy_r;
    assign bus.halted      = halted_r;
    assign bus.instr_count = instr_count_r;
    assign bus.cycle_count = cycle_count_r;

    // cnd only becomes valid in the WRITEBACK cycle itself, so the cmov
    // qualification is applied to the registered WRITEBACK phase here.
    assign bus.wb_en = wb_phase_r & ((bus.icode != 4'h2) | bus.cnd);

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed bench for y86_stage_sequencer: drives icode/status/ack on the
// falling edge and checks strobes, status and counters on the falling edge.
module tb_y86_stage_sequencer;

    localparam logic [6:0] SZ = 7'b0000000;
    localparam logic [6:0] SF = 7'b1000000;
    localparam logic [6:0] SD = 7'b0100000;
    localparam logic [6:0] SE = 7'b0010000;
    localparam logic [6:0] SC = 7'b0011000;
    localparam logic [6:0] SM = 7'b0000100;
    localparam logic [6:0] SW = 7'b0000010;
    localparam logic [6:0] SP = 7'b0000001;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    y86_stage_sequencer_if #(.CNT_W(32)) bus ();

    y86_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] strobes_s;
    assign strobes_s = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.cc_we,
                        bus.mem_req, bus.wb_en, bus.pc_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, {25'd0, strobes_s}, {25'd0, exp});
    endtask

    task automatic clear_inputs();
        bus.start         = 1'b0;
        bus.icode         = 4'h1;
        bus.invalid_instr = 1'b0;
        bus.imem_error    = 1'b0;
        bus.dmem_error    = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.cnd           = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_strobes", {25'd0, strobes_s}, 32'd0);
        chk("rst_stat", {29'd0, bus.stat}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_icnt", bus.instr_count, 32'd0);
        chk("rst_ccnt", bus.cycle_count, 32'd0);

        // nop, nop, halt
        rst_n = 1'b1;
        bus.icode = 4'h1;
        bus.start = 1'b1;
        step("nop1_f", SF); bus.start = 1'b0;
        chk("nop1_busy", {31'd0, bus.busy}, 32'd1);
        step("nop1_d", SD);
        step("nop1_e", SE);
        step("nop1_p", SP);
        step("nop2_f", SF);
        step("nop2_d", SD);
        step("nop2_e", SE);
        step("nop2_p", SP); bus.icode = 4'h0;
        step("hlt_f", SF);
        step("hlt_z", SZ);
        chk("hlt_halted", {31'd0, bus.halted}, 32'd1);
        chk("hlt_busy", {31'd0, bus.busy}, 32'd0);
        chk("hlt_stat", {29'd0, bus.stat}, 32'd2);
        chk("hlt_icnt", bus.instr_count, 32'd2);
        chk("hlt_ccnt", bus.cycle_count, 32'd9);
        bus.start = 1'b1;
        step("hlt_start_z", SZ); bus.start = 1'b0;
        step("hlt_start_z2", SZ);
        chk("hlt_stays", {31'd0, bus.halted}, 32'd1);
        chk("hlt_ccnt_hold", bus.cycle_count, 32'd9);

        // OPq, mrmovq (ack on 3rd MEMORY cycle), cmov false, rmmovq timeout
        apply_reset();
        bus.icode = 4'h6;
        bus.cnd   = 1'b0;
        bus.start = 1'b1;
        step("opq_f", SF); bus.start = 1'b0;
        step("opq_d", SD);
        step("opq_e_cc", SC);
        step("opq_w", SW);
        step("opq_p", SP); bus.icode = 4'h5;
        step("mr_f", SF);
        step("mr_d", SD);
        step("mr_e", SE);
        step("mr_m1", SM);
        step("mr_m2", SM);
        step("mr_m3", SM); bus.mem_ack = 1'b1;
        step("mr_w", SW); bus.mem_ack = 1'b0;
        step("mr_p", SP); bus.icode = 4'h2; bus.cnd = 1'b0;
        step("cmov_f", SF);
        step("cmov_d", SD);
        step("cmov_e", SE);
        step("cmov_wb_off", SZ);
        chk("cmov_wb_busy", {31'd0, bus.busy}, 32'd1);
        step("cmov_p", SP); bus.icode = 4'h4;
        step("rm_f", SF);
        step("rm_d", SD);
        step("rm_e", SE);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("rm_m%0d", i + 1), SM);
        end
        step("rm_tmo_z", SZ);
        chk("rm_tmo_halted", {31'd0, bus.halted}, 32'd1);
        chk("rm_tmo_stat", {29'd0, bus.stat}, 32'd3);
        chk("rm_tmo_icnt", bus.instr_count, 32'd3);
        chk("rm_tmo_ccnt", bus.cycle_count, 32'd29);

        // Ack on the timeout cycle wins; 1-cycle ack; dmem_error
        apply_reset();
        bus.icode = 4'h5;
        bus.start = 1'b1;
        step("late_f", SF); bus.start = 1'b0;
        step("late_d", SD);
        step("late_e", SE);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("late_m%0d", i + 1), SM);
        end
        step("late_m8", SM); bus.mem_ack = 1'b1;
        step("late_w", SW); bus.mem_ack = 1'b0;
        step("late_p", SP); bus.icode = 4'h4;
        step("fast_f", SF);
        step("fast_d", SD);
        step("fast_e", SE);
        step("fast_m1", SM); bus.mem_ack = 1'b1;
        step("fast_p", SP); bus.mem_ack = 1'b0; bus.icode = 4'h5;
        step("derr_f", SF);
        step("derr_d", SD);
        step("derr_e", SE);
        step("derr_m1", SM); bus.mem_ack = 1'b1; bus.dmem_error = 1'b1;
        step("derr_z", SZ); bus.mem_ack = 1'b0; bus.dmem_error = 1'b0;
        chk("derr_stat", {29'd0, bus.stat}, 32'd3);
        chk("derr_halted", {31'd0, bus.halted}, 32'd1);
        chk("derr_icnt", bus.instr_count, 32'd2);

        // Invalid instruction during FETCH
        apply_reset();
        bus.invalid_instr = 1'b1;
        bus.start = 1'b1;
        step("ins_f", SF); bus.start = 1'b0;
        step("ins_z", SZ);
        chk("ins_stat", {29'd0, bus.stat}, 32'd4);
        chk("ins_halted", {31'd0, bus.halted}, 32'd1);
        bus.invalid_instr = 1'b0;
        bus.start = 1'b1;
        step("ins_start_z", SZ); bus.start = 1'b0;
        step("ins_start_z2", SZ);
        chk("ins_stat_hold", {29'd0, bus.stat}, 32'd4);
        chk("ins_busy", {31'd0, bus.busy}, 32'd0);

        // imem_error outranks invalid_instr
        apply_reset();
        bus.imem_error = 1'b1;
        bus.invalid_instr = 1'b1;
        bus.start = 1'b1;
        step("imem_f", SF); bus.start = 1'b0;
        step("imem_z", SZ);
        chk("imem_stat", {29'd0, bus.stat}, 32'd3);

        // jXX then halt: 4 cycles
        apply_reset();
        bus.icode = 4'h7;
        bus.start = 1'b1;
        step("jxx_f", SF); bus.start = 1'b0;
        step("jxx_d", SD);
        step("jxx_e", SE);
        step("jxx_p", SP); bus.icode = 4'h0;
        step("jxx_hlt_f", SF);
        step("jxx_hlt_z", SZ);
        chk("jxx_icnt", bus.instr_count, 32'd1);
        chk("jxx_ccnt", bus.cycle_count, 32'd5);

        // Asynchronous reset in the middle of a MEMORY wait
        apply_reset();
        bus.icode = 4'h5;
        bus.start = 1'b1;
        step("arst_f", SF); bus.start = 1'b0;
        step("arst_d", SD);
        step("arst_e", SE);
        step("arst_m1", SM);
        step("arst_m2", SM);
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", {25'd0, strobes_s}, 32'd0);
        chk("arst_stat", {29'd0, bus.stat}, 32'd1);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_ccnt", bus.cycle_count, 32'd0);
        chk("arst_icnt", bus.instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("arst_idle", SZ);
        chk("arst_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
